// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
// Optional parity support is selected by the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int OS_RATE       = 16;
    localparam int OS_SAMPLE_MID = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY    = 3'd3,
`endif
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_e;

    // Per-character error flags stored alongside the data bits in each FIFO entry.
    typedef struct packed {
`ifdef UART_RX_PARITY_EN
        logic parity_err;
`endif
        logic frame_err;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit to tell full from empty.
module uart_rx_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign level    = wr_ptr_reg - rd_ptr_reg;
    assign empty    = (wr_ptr_reg == rd_ptr_reg);
    assign full     = (level == FULL_LEVEL);
    assign pop_ok   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// 16x oversampled UART receiver with majority voting and a receive FIFO.
// Define UART_RX_PARITY_EN to expect and check one parity bit per frame.
module uart_rx_fifo_ctrl
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          m_data,
    output logic                          m_frame_err,
    output logic                          m_parity_err,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV   = CLOCK_FREQ / (BAUD_RATE * OS_RATE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [3:0]       SAMPLE_A  = 4'(OS_SAMPLE_MID - 1);
    localparam logic [3:0]       SAMPLE_B  = 4'(OS_SAMPLE_MID);
    localparam logic [3:0]       SAMPLE_C  = 4'(OS_SAMPLE_MID + 1);
    localparam logic [3:0]       BIT_LAST  = 4'(OS_RATE - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    if (DIV < 1) begin : g_div_check
        $error("uart_rx_fifo_ctrl: CLOCK_FREQ/(BAUD_RATE*16) must be at least 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_check
        $error("uart_rx_fifo_ctrl: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_check
        $error("uart_rx_fifo_ctrl: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_parity_check
        $error("uart_rx_fifo_ctrl: PARITY_ODD must be 0 or 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_rx_fifo_ctrl: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef struct packed {
        uart_rx_status_t        status;
        logic [DATA_BITS-1:0]   data;
    } entry_t;

    uart_rx_state_e        state_reg, state_next;
    logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
    logic [3:0]            os_cnt_reg, os_cnt_next;
    logic [1:0]            samp_reg, samp_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic                  stop_cnt_reg, stop_cnt_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic                  frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                  parity_err_reg, parity_err_next;
`endif
    logic                  fall, maj, tick, decide, bit_end, push;
    logic                  fifo_full, fifo_empty;
    entry_t                push_entry, head_entry;

    assign fall = rx_prev_reg & ~rx_sync_reg;
    // The third vote is the live synchronised line at the decision tick.
    assign maj  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync_reg) |
                  (samp_reg[1] & rx_sync_reg);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rx_meta_reg    <= 1'b1;
            rx_sync_reg    <= 1'b1;
            rx_prev_reg    <= 1'b1;
            state_reg      <= IDLE;
            div_cnt_reg    <= '0;
            os_cnt_reg     <= '0;
            samp_reg       <= '0;
            bit_cnt_reg    <= '0;
            stop_cnt_reg   <= 1'b0;
            shift_reg      <= '0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else begin
            rx_meta_reg    <= rx;
            rx_sync_reg    <= rx_meta_reg;
            rx_prev_reg    <= rx_sync_reg;
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            os_cnt_reg     <= os_cnt_next;
            samp_reg       <= samp_next;
            bit_cnt_reg    <= bit_cnt_next;
            stop_cnt_reg   <= stop_cnt_next;
            shift_reg      <= shift_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_cnt_next   = div_cnt_reg;
        os_cnt_next    = os_cnt_reg;
        samp_next      = samp_reg;
        bit_cnt_next   = bit_cnt_reg;
        stop_cnt_next  = stop_cnt_reg;
        shift_next     = shift_reg;
        frame_err_next = frame_err_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err_reg;
        push_entry.status.parity_err = parity_err_reg;
`endif
        push_entry.status.frame_err = frame_err_reg | ~maj;
        push_entry.data = shift_reg;
        tick = 1'b0;
        push = 1'b0;

        if (state_reg != IDLE) begin
            if (div_cnt_reg == DIV_LAST) begin
                tick         = 1'b1;
                div_cnt_next = '0;
            end else begin
                div_cnt_next = div_cnt_reg + DIV_W'(1);
            end
        end
        if (tick) begin
            os_cnt_next = os_cnt_reg + 4'd1;
            if (os_cnt_reg == SAMPLE_A) samp_next[0] = rx_sync_reg;
            if (os_cnt_reg == SAMPLE_B) samp_next[1] = rx_sync_reg;
        end
        decide  = tick && (os_cnt_reg == SAMPLE_C);
        bit_end = tick && (os_cnt_reg == BIT_LAST);

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next     = START;
                    div_cnt_next   = '0;
                    os_cnt_next    = '0;
                    bit_cnt_next   = '0;
                    stop_cnt_next  = 1'b0;
                    frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
                    parity_err_next = 1'b0;
`endif
                end
            end
            START: begin
                if (decide && maj) state_next = IDLE;
                else if (bit_end)  state_next = DATA;
            end
            DATA: begin
                if (decide) begin
                    shift_next   = {maj, shift_reg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                end
                if (bit_end && bit_cnt_reg == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide && (maj != ((^shift_reg) ^ PARITY_ODD[0]))) parity_err_next = 1'b1;
                if (bit_end) state_next = STOP;
            end
`endif
            STOP: begin
                if (decide) begin
                    if (!maj) frame_err_next = 1'b1;
                    if (stop_cnt_reg == STOP_LAST) begin
                        push       = 1'b1;
                        state_next = rx_sync_reg ? IDLE : WAIT_HIGH;
                    end
                end
                if (bit_end) stop_cnt_next = 1'b1;
            end
            WAIT_HIGH: begin
                if (rx_sync_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    uart_rx_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (m_ready),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign m_valid     = !fifo_empty;
    assign m_data      = head_entry.data;
    assign m_frame_err = head_entry.status.frame_err;
`ifdef UART_RX_PARITY_EN
    assign m_parity_err = head_entry.status.parity_err;
`else
    assign m_parity_err = 1'b0;
`endif
    // Full FIFO means non-empty, so m_ready alone says whether a slot frees up.
    assign overrun_err = push && fifo_full && !m_ready;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Scoreboard bench for uart_rx_fifo_ctrl; honours UART_RX_PARITY_EN when defined.
module tb_uart_rx_fifo_ctrl;

    localparam int CLOCK_FREQ = 1600000;
    localparam int BAUD_RATE  = 10000;
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int PARITY_ODD = 0;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLKS   = CLOCK_FREQ / BAUD_RATE;
    localparam int TICK_CLKS  = BIT_CLKS / 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // rx fall -> 3 clocks to START, then the vote of the last stop bit is the
    // 10th tick of that bit; the push lands on this posedge after the fall.
    localparam int PUSH_EDGE = 3 + TICK_CLKS * (16 * (DATA_BITS + PAR_BITS + STOP_BITS) + 10);

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic rx = 1'b1;
    logic m_ready = 1'b0;
    logic [DATA_BITS-1:0] m_data;
    logic m_frame_err, m_parity_err, m_valid, overrun_err;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    typedef struct {
        logic [DATA_BITS-1:0] data;
        logic fe;
        logic pe;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int ovr_seen = 0;
    int ovr_exp = 0;

    uart_rx_fifo_ctrl #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .PARITY_ODD (PARITY_ODD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx           (rx),
        .m_data       (m_data),
        .m_frame_err  (m_frame_err),
        .m_parity_err (m_parity_err),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .overrun_err  (overrun_err),
        .fifo_level   (fifo_level)
    );

    always #5 clk = ~clk;

    // Monitor: every presented head is compared against the oldest expectation.
    always @(negedge clk) begin
        if (resetn) begin
            if (overrun_err === 1'b1) ovr_seen++;
            if (m_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_entry actual data=%02h fe=%0b pe=%0b required no entry",
                             m_data, m_frame_err, m_parity_err);
                end else if (m_data !== exp_q[0].data || m_frame_err !== exp_q[0].fe ||
                             m_parity_err !== exp_q[0].pe) begin
                    errors++;
                    $display("FAIL head actual data=%02h fe=%0b pe=%0b required data=%02h fe=%0b pe=%0b",
                             m_data, m_frame_err, m_parity_err, exp_q[0].data, exp_q[0].fe, exp_q[0].pe);
                end else if (m_ready === 1'b1) begin
                    $display("pop data=%02h fe=%0b pe=%0b level=%0d", m_data, m_frame_err,
                             m_parity_err, fifo_level);
                end
                if (m_ready === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected parity flag: the bench sends a wrong parity bit exactly when bad_par is set.
    function automatic logic exp_pe(input bit bad_par);
`ifdef UART_RX_PARITY_EN
        return bad_par;
`else
        return 1'b0 & bad_par;
`endif
    endfunction

    task automatic expect_entry(input logic [DATA_BITS-1:0] d, input logic fe, input logic pe,
                                input bit pop_at_push);
        exp_t e;
        e.data = d;
        e.fe   = fe;
        e.pe   = pe;
        if (exp_q.size() >= FIFO_DEPTH && !pop_at_push) begin
            ovr_exp++;
            $display("drop data=%02h expected (fifo full)", d);
        end else begin
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input logic [DATA_BITS-1:0] d, input bit bad_par, input bit bad_stop);
        $display("send data=%02h bad_par=%0b bad_stop=%0b", d, bad_par, bad_stop);
        rx = 1'b0;
        cyc(BIT_CLKS);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = d[i];
            cyc(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ PARITY_ODD[0] ^ bad_par;
        cyc(BIT_CLKS);
`endif
        for (int i = 0; i < STOP_BITS; i++) begin
            rx = !bad_stop;
            cyc(BIT_CLKS);
        end
        rx = 1'b1;
        if (bad_stop) cyc(BIT_CLKS);
    endtask

    task automatic frame(input logic [DATA_BITS-1:0] d, input bit bad_par, input bit bad_stop);
        expect_entry(d, bad_stop, exp_pe(bad_par), 1'b0);
        send_frame(d, bad_par, bad_stop);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20 * BIT_CLKS) begin
            @(posedge clk);
            n++;
        end
        cyc(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual=%0d pending required=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_m_data"}, 32'(m_data), 32'd0);
        check({tag, "_m_frame_err"}, 32'(m_frame_err), 32'd0);
        check({tag, "_m_parity_err"}, 32'(m_parity_err), 32'd0);
        check({tag, "_overrun_err"}, 32'(overrun_err), 32'd0);
        check({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
    endtask

    initial begin
        logic [DATA_BITS-1:0] d;
        bit bp, bs;

        cyc(5);
        resetn = 1'b1;
        cyc(1);
        check_reset_outputs("reset");

        // Back-to-back 8N1 frames with a ready consumer.
        m_ready = 1'b1;
        frame(8'hA5, 1'b0, 1'b0);
        frame(8'h3C, 1'b0, 1'b0);
        drain("back_to_back");

        // A short low glitch must be rejected by the start-bit vote.
        rx = 1'b0;
        cyc(40);
        rx = 1'b1;
        cyc(2 * BIT_CLKS);
        check("false_start_m_valid", 32'(m_valid), 32'd0);
        check("false_start_level", 32'(fifo_level), 32'd0);

`ifdef UART_RX_PARITY_EN
        frame(8'h07, 1'b1, 1'b0);
        frame(8'h07, 1'b0, 1'b0);
        drain("parity");
`endif

        // Break: one all-zero framing-error entry, then silence until rx rises.
        expect_entry('0, 1'b1, exp_pe(PARITY_ODD != 0), 1'b0);
        rx = 1'b0;
        cyc(30 * BIT_CLKS);
        check("break_single_entry", 32'(exp_q.size()), 32'd0);
        rx = 1'b1;
        cyc(BIT_CLKS);
        frame(8'h5A, 1'b0, 1'b0);
        drain("break");

        // Overrun: fifth frame into a full FIFO is dropped.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) frame(DATA_BITS'(i), 1'b0, 1'b0);
        cyc(BIT_CLKS);
        check("overrun_level", 32'(fifo_level), 32'(exp_q.size()));
        check("overrun_level_full", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));

        // Sixth frame arrives while full, with a pop in the push cycle.
        expect_entry(8'h06, 1'b0, 1'b0, 1'b1);
        fork
            send_frame(8'h06, 1'b0, 1'b0);
            begin
                cyc(PUSH_EDGE - 1);
                m_ready = 1'b1;
                cyc(1);
                m_ready = 1'b0;
            end
        join
        cyc(4);
        check("full_pop_level", 32'(fifo_level), 32'(FIFO_DEPTH));
        check("full_pop_no_overrun", 32'(ovr_seen), 32'(ovr_exp));
        m_ready = 1'b1;
        drain("overrun");

        // Reset in mid-frame discards both the partial frame and stored entries.
        m_ready = 1'b0;
        frame(8'h11, 1'b0, 1'b0);
        cyc(4);
        check("pre_reset_level", 32'(fifo_level), 32'd1);
        rx = 1'b0;
        cyc(500);
        resetn = 1'b0;
        exp_q.delete();
        rx = 1'b1;
        cyc(3);
        resetn = 1'b1;
        cyc(1);
        check_reset_outputs("mid_reset");
        cyc(2 * BIT_CLKS);
        check("post_reset_m_valid", 32'(m_valid), 32'd0);

        // Randomised frames with occasional parity and stop-bit errors.
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d  = DATA_BITS'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 3) == 0);
            frame(d, bp, bs);
            if ($urandom_range(0, 1) == 1) cyc(BIT_CLKS);
        end
        drain("random");
        check("final_overrun_pulses", 32'(ovr_seen), 32'(ovr_exp));
        check("final_level", 32'(fifo_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo_ctrl.md
# uart_rx_fifo_ctrl

Parametrised UART receiver for the SoC peripheral bus: 16x oversampled, majority-voted bit sampling, configurable frame format and a small receive FIFO with a valid/ready output. It replaces the fixed 8N1 receiver. Sits between the `rx` pad (via its own synchroniser) and the UART register block, which pops characters through the handshake.

## Interface
- `CLOCK_FREQ`, 50000000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in baud.
- `DATA_BITS`, 8, data bits per frame; legal range 5..9.
- `STOP_BITS`, 1, stop bits checked; legal values 1 or 2.
- `PARITY_ODD`, 0, parity type: 1 = odd, 0 = even. Used only with `UART_RX_PARITY_EN`.
- `FIFO_DEPTH`, 4, number of receive entries; power of 2, ≥2.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `rx`  in  1  asynchronous serial line; idles high.
- `m_data`  out  DATA_BITS  character at the FIFO head.
- `m_frame_err`  out  1  framing error flag for the head entry.
- `m_parity_err`  out  1  parity error flag for the head entry.
- `m_valid`  out  1  FIFO not empty.
- `m_ready`  in  1  consumer accepts the head entry.
- `overrun_err`  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- `rx` passes through a 2-flop synchroniser; both flops reset to 1.
- Tick divider: `DIV = CLOCK_FREQ/(BAUD_RATE*16)`, integer-truncated. `DIV < 1` is illegal (elaboration assertion).
- The divider emits a one-cycle `tick` every `DIV` clocks while the FSM is not IDLE. It is held at 0 in IDLE.
- A 4-bit `os_cnt` counts ticks within a bit. Samples are taken at `os_cnt` = 7, 8, 9. The bit value is the 2-of-3 majority, decided at `os_cnt` = 9.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - **IDLE**: a synchronised falling edge moves to START and clears the divider and `os_cnt`.
  - **START**: majority 1 means a false start; return to IDLE with nothing pushed. Majority 0 goes to DATA at `os_cnt` = 15.
  - **DATA**: shift LSB first. After `DATA_BITS` bits, go to PARITY if enabled, otherwise to STOP.
  - **PARITY**: compare the received bit with the computed parity. A mismatch sets the entry's `parity_err`.
  - **STOP**: each stop bit must be 1, otherwise set `frame_err`. At the decision sample of the last stop bit, push `{parity_err, frame_err, data}`. Then go to IDLE if the line is high, or to WAIT_HIGH if it is low (break / framing error).
  - **WAIT_HIGH**: stay until the synchronised `rx` is 1, then go to IDLE. This prevents a break from retriggering as a new frame.
- FIFO: circular buffer with read and write pointers one bit wider than the address. Pointers wrap modulo `FIFO_DEPTH`.
- Push while full drops the new frame, leaves the FIFO unchanged and pulses `overrun_err`.
- Pop occurs on `m_valid && m_ready`. With `m_valid` = 0, `m_ready` is ignored.
- Push and pop in the same cycle: both take effect and `fifo_level` is unchanged. This also applies when the FIFO is full, so no overrun occurs.
- `m_data`, `m_frame_err` and `m_parity_err` show the head entry whenever `m_valid` = 1. They hold stable until popped.

## Timing
- Reset values:
  - `m_valid` = 0, `m_data` = 0, `m_frame_err` = 0, `m_parity_err` = 0, `overrun_err` = 0, `fifo_level` = 0.
  - FSM in IDLE, pointers at 0.
- Reset asserted mid-frame aborts the frame. The partial character is discarded and FIFO contents are lost.
- Edge detect latency: 2 clocks of synchroniser plus 1 clock of edge register after the `rx` fall.
- Push occurs at the `clk` edge following the decision tick of the last stop bit. `m_valid` rises the next clock if the FIFO was empty.
- `overrun_err` pulses in the same cycle the push would have occurred.
- The receiver accepts back-to-back frames with no idle bits: the new falling edge is detected from IDLE after STOP.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - the PARITY state exists and one parity bit is expected after the data bits;
  - `PARITY_ODD` selects the parity type;
  - `m_parity_err` reports mismatches.
- `UART_RX_PARITY_EN` undefined:
  - no PARITY state and no parity bit in the frame;
  - `m_parity_err` is tied to 0;
  - the FIFO entry is one bit narrower.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_e`;
  - oversample constants `OS_RATE` = 16 and `OS_SAMPLE_MID` = 8;
  - packed struct for a FIFO entry.
- One sub-module, `uart_rx_sync_fifo`, parametrised by width and depth, with push/pop/full/empty/level. The serial FSM, divider and voter stay in the top module.

## Test plan
All scenarios use `CLOCK_FREQ` = 1600000 and `BAUD_RATE` = 10000, giving `DIV` = 10 and 160 clocks per bit.

- **8N1 back-to-back:** send 0xA5 then 0x3C with `m_ready` = 1. Expect `m_data` = 0xA5, then 0x3C, each for one `m_valid` cycle, with no error flags.
- **False start:** a 40-clock low glitch on `rx`. Expect return to IDLE, no push, `m_valid` stays 0.
- **Parity (macro on, even):** send 0x07 with parity bit 0. Expect `m_parity_err` = 1 with `m_data` = 0x07. With the correct parity bit 1, expect `m_parity_err` = 0.
- **Break:** hold `rx` low for 30 bit times. Expect one entry with `m_data` = 0x00 and `m_frame_err` = 1, then no further entries until `rx` rises and a new frame is sent.
- **Overrun:** `m_ready` = 0, send 5 frames 0x01..0x05 with `FIFO_DEPTH` = 4. Expect `fifo_level` = 4 and one `overrun_err` pulse, then pops return 0x01..0x04.
- **Full with simultaneous pop:** FIFO full, assert `m_ready` in the push cycle of a 6th frame. Expect no overrun and `fifo_level` to remain 4.
